pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall_i  input  1  hold PC; no PC update this cycle.
REQ-006 SHALL have port branch_i  input  1  conditional branch in execute.
REQ-007 SHALL have port jump_i  input  1  unconditional jump in execute.
REQ-008 SHALL have port funct3_i  input  3  branch condition select.
REQ-009 SHALL have ports alu_zero_i, alu_lt_i, alu_ltu_i  input  1 each  ALU flags: equal, signed less, unsigned less.
REQ-010 SHALL have port target_i  input  XLEN  branch/jump target address.
REQ-011 SHALL have port pc_o  output  XLEN  current PC (register).
REQ-012 SHALL have port pc_plus4_o  output  XLEN  pc_o + 4, modulo 2^XLEN.
REQ-013 SHALL have port flush_o  output  1  registered one-cycle flush of fetch/decode.
REQ-014 SHALL have port misalign_o  output  1  registered one-cycle misaligned-target trap.

Function
REQ-015 SHALL decode taken: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 never taken.
REQ-016 SHALL form redirect = (branch_i & taken) | jump_i; jump_i ignores funct3_i and flags.
REQ-017 SHALL treat a redirect with target_i[1:0] != 0 as misaligned: PC follows sequential path, misalign_o = 1 next cycle, no flush.
REQ-018 SHALL, with stall_i=0 and no pending redirect, load pc_o <= redirect ? target_i : pc_o+4 on each edge.
REQ-019 SHALL, on an aligned redirect while stall_i=1, capture target_i into a pending register; pc_o unchanged.
REQ-020 SHALL keep the first captured pending target; later redirects during the same stall are ignored.
REQ-021 SHALL, in the first unstalled cycle with a pending target, load pc_o <= pending target, clear pending, and ignore current-cycle redirect inputs.
REQ-022 SHALL assert flush_o for exactly one cycle following each edge on which pc_o is loaded from a target.
REQ-023 SHALL wrap pc_o+4 from 2^XLEN-4 to 0 without any flag.
REQ-024 SHALL use a two-state FSM: IDLE (no pending) -> HOLD on aligned redirect with stall_i=1; HOLD -> IDLE on stall_i=0.

Reset
REQ-025 SHALL, on rst=1 at any time, force pc_o=RESET_PC, FSM=IDLE, pending cleared, flush_o=0, misalign_o=0, counters 0.
REQ-026 SHALL discard any pending redirect when reset asserts mid-stall.

Configuration
REQ-027 SHALL, with PC_BRANCH_STATS_EN defined, add outputs branch_cnt_o and taken_cnt_o (32 bits, wrapping) counting accepted branch_i cycles and accepted taken branches; accepted means stall_i=0 or captured into pending.
REQ-028 SHALL, without PC_BRANCH_STATS_EN, omit counter logic and ports entirely; all other behaviour identical.

Structure
REQ-029 SHALL place funct3 condition constants (BEQ..BGEU), FSM state typedef and XLEN default in shared package pc_pkg.
REQ-030 SHALL implement the condition decode as combinational sub-module branch_cond (funct3 + flags -> taken).

Verification
REQ-031 Reset: rst=1 mid-run with RESET_PC=32'h100 -> pc_o=32'h100 immediately, flush_o=0.
REQ-032 BNE: pc_o=32'h20, branch_i=1, funct3=001, alu_zero_i=0, target=32'h40 -> next pc_o=32'h40, flush_o=1 one cycle; funct3=000 same flags -> pc_o=32'h24.
REQ-033 Stall capture: jump_i=1 target=32'h80 with stall_i=1 for 3 cycles, second jump target=32'hC0 in cycle 2 -> pc_o held, then 32'h80 after release, single flush pulse.
REQ-034 Misaligned: jump_i=1 target=32'h42, pc_o=32'h10 -> pc_o=32'h14, misalign_o=1 one cycle, flush_o=0.
REQ-035 Wrap: pc_o=32'hFFFF_FFFC, no redirect -> pc_o=0, pc_plus4_o=4.
REQ-036 Stats (PC_BRANCH_STATS_EN): 5 branches, 2 taken, one while stalled -> branch_cnt_o=5, taken_cnt_o=2.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC / branch unit: branch condition codes,
// the redirect FSM state type and the default PC width.
package pc_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3 encodings of the conditional branches
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // IDLE: no redirect waiting; HOLD: redirect captured during a stall
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: maps funct3 and the ALU compare flags to a
// taken indication. Unused encodings (010/011) never take.
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       alu_zero_i,
  input  logic       alu_lt_i,
  input  logic       alu_ltu_i,
  output logic       taken_o
);

  // Select the flag (or its inverse) named by funct3
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = alu_zero_i;
      BNE:     taken_o = ~alu_zero_i;
      BLT:     taken_o = alu_lt_i;
      BGE:     taken_o = ~alu_lt_i;
      BLTU:    taken_o = alu_ltu_i;
      BGEU:    taken_o = ~alu_ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump redirect, stall-time redirect capture,
// misaligned-target trap and fetch/decode flush generation.
// Optional feature: define PC_BRANCH_STATS_EN to add branch statistics
// counters (branch_cnt_o, taken_cnt_o).
//
// Flow control: stall_i=1 freezes pc_o for that cycle. An aligned redirect
// seen while stalled is remembered (first one wins) and applied in the first
// cycle with stall_i=0; redirect inputs in that release cycle are ignored.
// state_o exposes the FSM state (1 = HOLD, a redirect is pending).
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic [2:0]      funct3_i,
  input  logic            alu_zero_i,
  input  logic            alu_lt_i,
  input  logic            alu_ltu_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic            state_o
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     taken_cnt_o
`endif
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  logic taken;
  logic redirect;
  logic misal;
  logic aligned_redir;

  branch_cond u_cond (
    .funct3_i   (funct3_i),
    .alu_zero_i (alu_zero_i),
    .alu_lt_i   (alu_lt_i),
    .alu_ltu_i  (alu_ltu_i),
    .taken_o    (taken)
  );

  assign redirect      = (branch_i & taken) | jump_i;
  assign misal         = redirect & (target_i[1:0] != 2'b00);
  assign aligned_redir = redirect & ~misal;

  assign pc_plus4_o = pc_q + XLEN'(4);
  assign pc_o       = pc_q;
  assign flush_o    = flush_q;
  assign misalign_o = misalign_q;
  assign state_o    = (state_q == ST_HOLD);

  // Next PC, pending-target capture and one-cycle flush/trap pulses
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall_i) begin
          // A misaligned target falls back to the sequential path
          if (aligned_redir) begin
            pc_d    = target_i;
            flush_d = 1'b1;
          end else begin
            pc_d = pc_plus4_o;
          end
          misalign_d = misal;
        end else if (aligned_redir) begin
          pend_d  = target_i;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Later redirects during the stall are dropped; the pending target wins
        if (!stall_i) begin
          pc_d    = pend_q;
          pend_d  = '0;
          flush_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards any pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        accept;

  // A branch counts when it is acted on now or captured as the pending target
  always_comb begin
    accept       = (state_q == ST_IDLE) & (~stall_i | aligned_redir);
    branch_cnt_d = branch_cnt_q + {31'd0, branch_i & accept};
    taken_cnt_d  = taken_cnt_q + {31'd0, branch_i & taken & accept};
  end

  // Free-running wrapping statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit (RESET_PC = 32'h100).
module tb_pc_branch_unit;

  localparam int XLEN = 32;

  typedef logic [2*XLEN+2:0] obs_t;

  typedef struct packed {
    logic        stall;
    logic        branch;
    logic        jump;
    logic [2:0]  f3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] target;
  } stim_t;

  logic            clk;
  logic            rst;
  logic            stall_i;
  logic            branch_i;
  logic            jump_i;
  logic [2:0]      funct3_i;
  logic            alu_zero_i;
  logic            alu_lt_i;
  logic            alu_ltu_i;
  logic [XLEN-1:0] target_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic            flush_o;
  logic            misalign_o;
  logic            state_o;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0]     branch_cnt_o;
  logic [31:0]     taken_cnt_o;
`endif

  obs_t exp_q[$];
  int   checks;
  int   errors;

  pc_branch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .branch_i   (branch_i),
    .jump_i     (jump_i),
    .funct3_i   (funct3_i),
    .alu_zero_i (alu_zero_i),
    .alu_lt_i   (alu_lt_i),
    .alu_ltu_i  (alu_ltu_i),
    .target_i   (target_i),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .flush_o    (flush_o),
    .misalign_o (misalign_o),
    .state_o    (state_o)
`ifdef PC_BRANCH_STATS_EN
    ,
    .branch_cnt_o (branch_cnt_o),
    .taken_cnt_o  (taken_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers (stimulus / expected packing) ----------------
  function automatic stim_t mk(logic stall, logic branch, logic jump, logic [2:0] f3,
                               logic zero, logic lt, logic ltu, logic [31:0] target);
    stim_t s;
    s.stall = stall; s.branch = branch; s.jump = jump; s.f3 = f3;
    s.zero = zero; s.lt = lt; s.ltu = ltu; s.target = target;
    return s;
  endfunction

  function automatic obs_t pack(logic [31:0] pc, logic f, logic m, logic s);
    return {pc, pc + 32'd4, f, m, s};
  endfunction

  function automatic obs_t observe();
    return {pc_o, pc_plus4_o, flush_o, misalign_o, state_o};
  endfunction

  function automatic logic ref_taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input stim_t s);
    stall_i    = s.stall;
    branch_i   = s.branch;
    jump_i     = s.jump;
    funct3_i   = s.f3;
    alu_zero_i = s.zero;
    alu_lt_i   = s.lt;
    alu_ltu_i  = s.ltu;
    target_i   = s.target;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t got, exp;
    exp_q.push_back(pack(32'h100, 1'b0, 1'b0, 1'b0));
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_init got %h exp %h", got, exp); end

    drive(mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h40));
    exp_q.push_back(pack(32'h40, 1'b1, 1'b0, 1'b0));
    step();
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pre_reset got %h exp %h", got, exp); end

    rst = 1'b1;
    exp_q.push_back(pack(32'h100, 1'b0, 1'b0, 1'b0));
    #1;
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset got %h exp %h", got, exp); end
    #1 rst = 1'b0;

    drive(mk(1, 0, 1, 3'b000, 0, 0, 0, 32'h80));
    exp_q.push_back(pack(32'h100, 1'b0, 1'b0, 1'b1));
    step();
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL hold_before_reset got %h exp %h", got, exp); end

    rst = 1'b1;
    exp_q.push_back(pack(32'h100, 1'b0, 1'b0, 1'b0));
    #1;
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_clears_hold got %h exp %h", got, exp); end
    #1 rst = 1'b0;

    drive(mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    exp_q.push_back(pack(32'h104, 1'b0, 1'b0, 1'b0));
    step();
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pending_discarded got %h exp %h", got, exp); end
`ifdef PC_BRANCH_STATS_EN
    checks++;
    if (branch_cnt_o !== 32'd0 || taken_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_cnt_o, taken_cnt_o);
    end
`endif
  endtask

`ifdef PC_BRANCH_STATS_EN
  task automatic test_stats();
    stim_t s[8];
    obs_t  e[8];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h100); e[0] = pack(32'h100, 1, 0, 0);
    s[1] = mk(0, 1, 0, 3'b000, 1, 0, 0, 32'h200); e[1] = pack(32'h200, 1, 0, 0);
    s[2] = mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h280); e[2] = pack(32'h204, 0, 0, 0);
    s[3] = mk(1, 1, 0, 3'b001, 0, 0, 0, 32'h300); e[3] = pack(32'h204, 0, 0, 1);
    s[4] = mk(0, 1, 0, 3'b001, 0, 0, 0, 32'h400); e[4] = pack(32'h300, 1, 0, 0);
    s[5] = mk(0, 1, 0, 3'b100, 0, 0, 0, 32'h500); e[5] = pack(32'h304, 0, 0, 0);
    s[6] = mk(0, 1, 0, 3'b010, 1, 1, 1, 32'h600); e[6] = pack(32'h308, 0, 0, 0);
    s[7] = mk(1, 1, 0, 3'b000, 0, 0, 0, 32'h700); e[7] = pack(32'h308, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stats_seq[%0d] got %h exp %h", i, got, exp); end
    end
    checks++;
    if (branch_cnt_o !== 32'd5) begin
      errors++; $display("FAIL branch_cnt got %0d exp 5", branch_cnt_o);
    end
    checks++;
    if (taken_cnt_o !== 32'd2) begin
      errors++; $display("FAIL taken_cnt got %0d exp 2", taken_cnt_o);
    end
  endtask
`endif

  task automatic test_bne();
    stim_t s[7];
    obs_t  e[7];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h20); e[0] = pack(32'h20, 1, 0, 0);
    s[1] = mk(0, 1, 0, 3'b001, 0, 0, 0, 32'h40); e[1] = pack(32'h40, 1, 0, 0);
    s[2] = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);  e[2] = pack(32'h44, 0, 0, 0);
    s[3] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h20); e[3] = pack(32'h20, 1, 0, 0);
    s[4] = mk(0, 1, 0, 3'b000, 0, 0, 0, 32'h40); e[4] = pack(32'h24, 0, 0, 0);
    s[5] = mk(0, 1, 0, 3'b101, 0, 1, 0, 32'h80); e[5] = pack(32'h28, 0, 0, 0);
    s[6] = mk(0, 1, 0, 3'b111, 0, 0, 0, 32'h80); e[6] = pack(32'h80, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bne[%0d] got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_stall_capture();
    stim_t s[6];
    obs_t  e[6];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h10);  e[0] = pack(32'h10, 1, 0, 0);
    s[1] = mk(1, 0, 1, 3'b000, 0, 0, 0, 32'h80);  e[1] = pack(32'h10, 0, 0, 1);
    s[2] = mk(1, 0, 1, 3'b000, 0, 0, 0, 32'hC0);  e[2] = pack(32'h10, 0, 0, 1);
    s[3] = mk(1, 0, 0, 3'b000, 0, 0, 0, 32'h0);   e[3] = pack(32'h10, 0, 0, 1);
    s[4] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h200); e[4] = pack(32'h80, 1, 0, 0);
    s[5] = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);   e[5] = pack(32'h84, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_capture[%0d] got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_misaligned();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h10); e[0] = pack(32'h10, 1, 0, 0);
    s[1] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h42); e[1] = pack(32'h14, 0, 1, 0);
    s[2] = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);  e[2] = pack(32'h18, 0, 0, 0);
    s[3] = mk(0, 1, 0, 3'b001, 0, 0, 0, 32'h1E); e[3] = pack(32'h1C, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL misaligned[%0d] got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_wrap();
    stim_t s[2];
    obs_t  e[2];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'hFFFF_FFFC); e[0] = pack(32'hFFFF_FFFC, 1, 0, 0);
    s[1] = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);         e[1] = pack(32'h0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wrap[%0d] got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got, exp;
    s[0] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h500); e[0] = pack(32'h500, 1, 0, 0);
    s[1] = mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h600); e[1] = pack(32'h600, 1, 0, 0);
    s[2] = mk(1, 0, 0, 3'b000, 0, 0, 0, 32'h0);   e[2] = pack(32'h600, 0, 0, 0);
    s[3] = mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0);   e[3] = pack(32'h604, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      exp_q.push_back(e[i]);
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL back_to_back[%0d] got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_random_cond();
    obs_t        got, exp;
    logic [31:0] model_pc;
    logic [2:0]  f3;
    logic        z, lt, ltu, tk;
    logic [31:0] tgt;
    drive(mk(0, 0, 1, 3'b000, 0, 0, 0, 32'h1000));
    exp_q.push_back(pack(32'h1000, 1, 0, 0));
    step();
    got = observe(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rand_setup got %h exp %h", got, exp); end
    model_pc = 32'h1000;
    for (int i = 0; i < 24; i++) begin
      f3  = 3'($urandom_range(0, 7));
      z   = 1'($urandom_range(0, 1));
      lt  = 1'($urandom_range(0, 1));
      ltu = 1'($urandom_range(0, 1));
      tgt = $urandom() & 32'hFFFF_FFFC;
      tk  = ref_taken(f3, z, lt, ltu);
      drive(mk(0, 1, 0, f3, z, lt, ltu, tgt));
      model_pc = tk ? tgt : model_pc + 32'd4;
      exp_q.push_back(pack(model_pc, tk, 1'b0, 1'b0));
      step();
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_cond[%0d] f3=%b z=%b lt=%b ltu=%b got %h exp %h", i, f3, z, lt, ltu, got, exp);
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(mk(0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    #12 rst = 1'b0;
    test_reset();
`ifdef PC_BRANCH_STATS_EN
    test_stats();
`endif
    test_bne();
    test_stall_capture();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_random_cond();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
